// File: rtl/mul_share_sequencer.sv
// Shared signed DATA_W x DATA_W shift-add multiplier sequencer with 2-requester arbitration.
// Latency: oGnt in cycle t, oDone/write strobes in cycle t+DATA_W+1, next grant no earlier than t+DATA_W+3.
// Backpressure: requests are level-held until their oGnt bit pulses; requests outside IDLE wait, they are not dropped.
// Optional feature macro: MUL_SHARE_RR_EN (round-robin arbitration; undefined = fixed priority, requester 0 first).
module mul_share_sequencer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [1:0]        iReq,
  input  logic [DATA_W-1:0] iOpA0,
  input  logic [DATA_W-1:0] iOpB0,
  input  logic [DATA_W-1:0] iOpA1,
  input  logic [DATA_W-1:0] iOpB1,
  input  logic [ADDR_W-1:0] iDest0,
  input  logic [ADDR_W-1:0] iDest1,
  output logic [1:0]        oGnt,
  output logic              oBusy,
  output logic              oDone,
  output logic              oDoneId,
  output logic [DATA_W-1:0] oResultLo,
  output logic [DATA_W-1:0] oResultHi,
  output logic [ADDR_W-1:0] oWriteAddress,
  output logic              oWriteEnable,
  output logic              oMulEnable
);

  localparam int ACC_W = 2 * DATA_W;
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FIX   = 2'd2,
    S_WRITE = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               id_q, id_d;
  logic [ADDR_W-1:0]  dest_q, dest_d;
  logic               sign_q, sign_d;
  // |A| keeps one extra bit so that -2^(DATA_W-1) has an exact magnitude.
  logic [DATA_W:0]    mag_a_q, mag_a_d;
  // |B| never exceeds 2^(DATA_W-1), so DATA_W bits always hold it exactly.
  logic [DATA_W-1:0]  mag_b_q, mag_b_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [1:0]         gnt_q, gnt_d;
  logic [DATA_W-1:0]  res_lo_q, res_lo_d;
  logic [DATA_W-1:0]  res_hi_q, res_hi_d;
  logic [ADDR_W-1:0]  out_addr_q, out_addr_d;
  logic               out_id_q, out_id_d;
`ifdef MUL_SHARE_RR_EN
  logic               rr_q, rr_d;
`endif

  // Arbitration and operand selection signals.
  logic               req_any;
  logic               win;
  logic [DATA_W-1:0]  sel_a;
  logic [DATA_W-1:0]  sel_b;
  logic [DATA_W:0]    a_ext;
  logic [DATA_W:0]    sel_mag_a;
  logic [DATA_W-1:0]  sel_mag_b;
  logic               sel_sign;
  logic [ACC_W-1:0]   addend;
  logic [ACC_W-1:0]   prod;

  // Pick the winning requester and precompute its sign and operand magnitudes.
  always_comb begin
    req_any = |iReq;
`ifdef MUL_SHARE_RR_EN
    // On a tie the requester that did not win last time is served.
    if (iReq == 2'b11) begin
      win = ~rr_q;
    end else begin
      win = iReq[1];
    end
`else
    // Requester 0 wins whenever it is asking.
    win = ~iReq[0];
`endif
    sel_a     = win ? iOpA1 : iOpA0;
    sel_b     = win ? iOpB1 : iOpB0;
    a_ext     = {sel_a[DATA_W-1], sel_a};
    sel_mag_a = a_ext[DATA_W] ? (~a_ext + 1'b1) : a_ext;
    sel_mag_b = sel_b[DATA_W-1] ? (~sel_b + 1'b1) : sel_b;
    // A zero operand gives a zero product, so the sign is forced positive.
    sel_sign  = (sel_a[DATA_W-1] ^ sel_b[DATA_W-1]) && (|sel_a) && (|sel_b);
    addend    = ACC_W'(mag_a_q) << cnt_q;
    prod      = sign_q ? (~acc_q + 1'b1) : acc_q;
  end

  // Next-state and datapath update for the IDLE -> RUN -> FIX -> WRITE sequence.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    id_d       = id_q;
    dest_d     = dest_q;
    sign_d     = sign_q;
    mag_a_d    = mag_a_q;
    mag_b_d    = mag_b_q;
    acc_d      = acc_q;
    gnt_d      = 2'b00;
    res_lo_d   = res_lo_q;
    res_hi_d   = res_hi_q;
    out_addr_d = out_addr_q;
    out_id_d   = out_id_q;
`ifdef MUL_SHARE_RR_EN
    rr_d       = rr_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (req_any) begin
          state_d    = S_RUN;
          cnt_d      = '0;
          id_d       = win;
          dest_d     = win ? iDest1 : iDest0;
          sign_d     = sel_sign;
          mag_a_d    = sel_mag_a;
          mag_b_d    = sel_mag_b;
          acc_d      = '0;
          gnt_d[win] = 1'b1;
`ifdef MUL_SHARE_RR_EN
          rr_d       = win;
`endif
        end
      end

      S_RUN: begin
        // One multiplier bit per cycle, always the full DATA_W iterations.
        if (mag_b_q[cnt_q]) begin
          acc_d = acc_q + addend;
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        // Result registers change only here, so they hold until the next WRITE.
        res_lo_d   = prod[DATA_W-1:0];
        res_hi_d   = prod[ACC_W-1:DATA_W];
        out_addr_d = dest_q;
        out_id_d   = id_q;
        state_d    = S_WRITE;
      end

      S_WRITE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register with synchronous reset; reset aborts any operation in flight.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      id_q       <= 1'b0;
      dest_q     <= '0;
      sign_q     <= 1'b0;
      mag_a_q    <= '0;
      mag_b_q    <= '0;
      acc_q      <= '0;
      gnt_q      <= 2'b00;
      res_lo_q   <= '0;
      res_hi_q   <= '0;
      out_addr_q <= '0;
      out_id_q   <= 1'b0;
`ifdef MUL_SHARE_RR_EN
      rr_q       <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      id_q       <= id_d;
      dest_q     <= dest_d;
      sign_q     <= sign_d;
      mag_a_q    <= mag_a_d;
      mag_b_q    <= mag_b_d;
      acc_q      <= acc_d;
      gnt_q      <= gnt_d;
      res_lo_q   <= res_lo_d;
      res_hi_q   <= res_hi_d;
      out_addr_q <= out_addr_d;
      out_id_q   <= out_id_d;
`ifdef MUL_SHARE_RR_EN
      rr_q       <= rr_d;
`endif
    end
  end

  // Strobes are decoded from the WRITE state; data outputs come straight from registers.
  always_comb begin
    oGnt          = gnt_q;
    oBusy         = (state_q != S_IDLE);
    oDone         = (state_q == S_WRITE);
    oWriteEnable  = (state_q == S_WRITE);
    oMulEnable    = (state_q == S_WRITE);
    oDoneId       = out_id_q;
    oResultLo     = res_lo_q;
    oResultHi     = res_hi_q;
    oWriteAddress = out_addr_q;
  end

endmodule

// File: tb/tb_mul_share_sequencer.sv
// Scoreboard bench for mul_share_sequencer: expected products queued at issue, compared at oDone.
// Covers reset values, latency, signed corner cases, arbitration, held/withdrawn requests and mid-run reset.
// Expected products come from a direct signed multiply, independent of the shift-add engine.
module tb_mul_share_sequencer;

  localparam int DW = 16;
  localparam int AW = 8;

  logic          Clock = 1'b0;
  logic          Reset;
  logic [1:0]    iReq;
  logic [DW-1:0] iOpA0, iOpB0, iOpA1, iOpB1;
  logic [AW-1:0] iDest0, iDest1;
  logic [1:0]    oGnt;
  logic          oBusy, oDone, oDoneId, oWriteEnable, oMulEnable;
  logic [DW-1:0] oResultLo, oResultHi;
  logic [AW-1:0] oWriteAddress;

  mul_share_sequencer #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .Clock(Clock), .Reset(Reset), .iReq(iReq),
    .iOpA0(iOpA0), .iOpB0(iOpB0), .iOpA1(iOpA1), .iOpB1(iOpB1),
    .iDest0(iDest0), .iDest1(iDest1),
    .oGnt(oGnt), .oBusy(oBusy), .oDone(oDone), .oDoneId(oDoneId),
    .oResultLo(oResultLo), .oResultHi(oResultHi),
    .oWriteAddress(oWriteAddress), .oWriteEnable(oWriteEnable), .oMulEnable(oMulEnable)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic          id;
    logic [DW-1:0] lo;
    logic [DW-1:0] hi;
    logic [AW-1:0] addr;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   gnt_cnt = 0;

`ifdef MUL_SHARE_RR_EN
  localparam logic [1:0] EXP_G [3] = '{2'b01, 2'b10, 2'b01};
`else
  localparam logic [1:0] EXP_G [3] = '{2'b01, 2'b01, 2'b01};
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic id, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                 input logic [AW-1:0] d);
    logic signed [2*DW-1:0] sa, sb, p;
    exp_t e;
    sa = $signed(a);
    sb = $signed(b);
    p  = sa * sb;
    e.id   = id;
    e.lo   = p[DW-1:0];
    e.hi   = p[2*DW-1:DW];
    e.addr = d;
    return e;
  endfunction

  always @(posedge Clock) cyc <= cyc + 1;

  // Output monitor: every completion is checked against the head of the scoreboard.
  always @(negedge Clock) begin
    exp_t e;
    if (!Reset && (|oGnt)) gnt_cnt++;
    if (!Reset && oDone) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("res_lo", oResultLo, e.lo);
        chk("res_hi", oResultHi, e.hi);
        chk("wr_addr", oWriteAddress, e.addr);
        chk("done_id", oDoneId, e.id);
        chk("wr_en", oWriteEnable, 1);
        chk("mul_en", oMulEnable, 1);
      end
    end
  end

  task automatic set_ops(input logic id, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [AW-1:0] d);
    if (id) begin iOpA1 = a; iOpB1 = b; iDest1 = d; end
    else    begin iOpA0 = a; iOpB0 = b; iDest0 = d; end
  endtask

  task automatic wait_gnt(input logic [1:0] mask, output int gc);
    gc = -1;
    for (int n = 0; n < 60; n++) begin
      @(negedge Clock);
      if ((oGnt & mask) != 2'b00) begin
        gc = cyc;
        break;
      end
    end
    if (gc < 0) chk("gnt_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done(output int dc);
    dc = -1;
    for (int n = 0; n < 60; n++) begin
      @(negedge Clock);
      if (oDone) begin
        dc = cyc;
        break;
      end
    end
    if (dc < 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  // Single transaction: queue expectation, hold request until granted, scramble operands, check latency and hold.
  task automatic run_one(input logic id, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [AW-1:0] d);
    int gc, dc;
    exp_t e;
    e = model(id, a, b, d);
    set_ops(id, a, b, d);
    sb_q.push_back(e);
    iReq[id] = 1'b1;
    wait_gnt(id ? 2'b10 : 2'b01, gc);
    iReq[id] = 1'b0;
    chk("busy_run", oBusy, 1);
    set_ops(id, ~a, b + 16'h1357, ~d);
    wait_done(dc);
    chk("latency", dc - gc, DW + 1);
    @(negedge Clock);
    chk("done_pulse", oDone, 0);
    chk("hold_lo", oResultLo, e.lo);
    chk("hold_hi", oResultHi, e.hi);
  endtask

  initial begin
    int gc, dc, g0;
    Reset = 1'b1;
    iReq  = 2'b00;
    set_ops(0, '0, '0, '0);
    set_ops(1, '0, '0, '0);
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0;

    chk("rst_gnt", oGnt, 0);
    chk("rst_busy", oBusy, 0);
    chk("rst_done", oDone, 0);
    chk("rst_lo", oResultLo, 0);
    chk("rst_hi", oResultHi, 0);
    chk("rst_addr", oWriteAddress, 0);
    chk("rst_we", {oWriteEnable, oMulEnable, oDoneId}, 0);

    // Directed arithmetic cases, including the most negative operand and zeros.
    run_one(0, 16'd3, 16'd5, 8'h04);
    chk("t1_lo_const", oResultLo, 32'h000F);
    run_one(1, 16'hFFFE, 16'd7, 8'h11);
    chk("t2_hi_const", oResultHi, 32'hFFFF);
    run_one(0, 16'h8000, 16'h8000, 8'h20);
    chk("t3_hi_const", oResultHi, 32'h4000);
    run_one(1, 16'h8000, 16'h0001, 8'h21);
    run_one(0, 16'h0000, 16'h8123, 8'h22);
    run_one(1, 16'hF000, 16'h0000, 8'h23);
    run_one(0, 16'h7FFF, 16'h7FFF, 8'h24);
    run_one(1, 16'h7FFF, 16'h8000, 8'h25);
    for (int k = 0; k < 6; k++) begin
      run_one(k[0], 16'($urandom), 16'($urandom), 8'($urandom));
    end

    // Request raised during a run is served immediately after that run completes.
    set_ops(0, 16'd100, 16'hFF9C, 8'h30);
    sb_q.push_back(model(0, 16'd100, 16'hFF9C, 8'h30));
    iReq[0] = 1'b1;
    wait_gnt(2'b01, gc);
    iReq[0] = 1'b0;
    set_ops(1, 16'd1234, 16'd4321, 8'h31);
    sb_q.push_back(model(1, 16'd1234, 16'd4321, 8'h31));
    iReq[1] = 1'b1;
    wait_done(dc);
    wait_gnt(2'b10, gc);
    iReq[1] = 1'b0;
    chk("late_req_gap", gc - dc, 2);
    wait_done(dc);

    // Request withdrawn before reaching IDLE gets no grant.
    @(negedge Clock);
    g0 = gnt_cnt;
    set_ops(0, 16'd9, 16'd9, 8'h40);
    sb_q.push_back(model(0, 16'd9, 16'd9, 8'h40));
    iReq[0] = 1'b1;
    wait_gnt(2'b01, gc);
    iReq[0] = 1'b0;
    iReq[1] = 1'b1;
    repeat (4) @(negedge Clock);
    iReq[1] = 1'b0;
    wait_done(dc);
    repeat (6) @(negedge Clock);
    chk("withdraw_gnts", gnt_cnt - g0, 1);

    // Reset in the middle of RUN aborts the operation.
    set_ops(0, 16'd77, 16'd55, 8'h50);
    iReq[0] = 1'b1;
    wait_gnt(2'b01, gc);
    iReq[0] = 1'b0;
    repeat (8) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    chk("mid_rst_busy", oBusy, 0);
    chk("mid_rst_lo", oResultLo, 0);
    chk("mid_rst_hi", oResultHi, 0);
    chk("mid_rst_addr", oWriteAddress, 0);
    repeat (25) @(negedge Clock);
    run_one(1, 16'd300, 16'hFFFD, 8'h51);

    // Both requesters held: arbitration order, then requester 0 drops.
    set_ops(0, 16'd11, 16'd13, 8'h60);
    set_ops(1, 16'hFFF5, 16'd17, 8'h61);
    iReq = 2'b11;
    for (int k = 0; k < 3; k++) begin
      wait_gnt(2'b11, gc);
      chk("dual_gnt", oGnt, EXP_G[k]);
      if (EXP_G[k][1]) sb_q.push_back(model(1, 16'hFFF5, 16'd17, 8'h61));
      else             sb_q.push_back(model(0, 16'd11, 16'd13, 8'h60));
    end
    iReq = 2'b10;
    wait_gnt(2'b11, gc);
    chk("dual_last_gnt", oGnt, 2'b10);
    sb_q.push_back(model(1, 16'hFFF5, 16'd17, 8'h61));
    iReq = 2'b00;
    wait_done(dc);
    repeat (4) @(negedge Clock);

    chk("sb_empty", sb_q.size(), 0);
    chk("idle_end", oBusy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
